// File: rtl/int_controller.sv
// Interrupt controller: arbitrates one soft source and two edge-triggered hard
// lines, then sequences decoder state-save, PC vector load and service until iret.
//
// Handshake: there is no valid/ready pair here. o_interrupt and o_pc_load are
// single-cycle strobes that the decoder and PC must act on in the cycle they are
// high. o_int_vector is only meaningful while o_pc_load=1 and reads 0 otherwise.
module int_controller #(
  parameter logic [15:0] VEC_A_DEFAULT = 16'h0010,
  parameter logic [15:0] VEC_B_DEFAULT = 16'h0020,
  parameter logic [15:0] SOFT_BASE     = 16'h0100,
  parameter int          SOFT_SHIFT    = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [11:0] i_ct_code,
  input  logic [15:0] i_data_bus,
  input  logic        i_int_a,
  input  logic        i_int_b,
  input  logic        i_iret,
  output logic        o_interrupt,
  output logic        o_pc_load,
  output logic [15:0] o_int_vector,
  output logic        o_int_busy,
  output logic [1:0]  o_int_source,
  output logic        o_soft_drop,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    VECTOR  = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t      state;
  logic        inta_en, intb_en, prio;
  logic [15:0] vec_a, vec_b, vec_lat;
  logic        pend_a, pend_b, prev_a, prev_b;
  logic        soft_pend;
  logic [4:0]  soft_num;

  logic        take_soft, take_a, take_b;
  logic [1:0]  sel_src;
  logic [15:0] sel_vec, soft_vec;
  logic        kill_a, kill_b, soft_accept;

  assign dbg_state   = state;
  assign soft_vec    = SOFT_BASE + (16'(soft_num) << SOFT_SHIFT);
  // Writing an enable to 0 discards whatever that line had pending.
  assign kill_a      = i_ct_code[3] & ~i_ct_code[0];
  assign kill_b      = i_ct_code[3] & ~i_ct_code[1];
  assign soft_accept = i_ct_code[6] & ~soft_pend;

  // Arbitration in IDLE: soft first, then A/B ordered by prio.
  always_comb begin
    take_soft = 1'b0;
    take_a    = 1'b0;
    take_b    = 1'b0;
    if (state == IDLE) begin
      if (soft_pend)                  take_soft = 1'b1;
      else if (pend_a && pend_b) begin
        if (prio)                     take_b = 1'b1;
        else                          take_a = 1'b1;
      end
      else if (pend_a)                take_a = 1'b1;
      else if (pend_b)                take_b = 1'b1;
    end
    sel_src = take_soft ? 2'd3 : take_b ? 2'd2 : take_a ? 2'd1 : 2'd0;
    sel_vec = take_soft ? soft_vec : take_b ? vec_b : vec_a;
  end

  // Configuration registers written from the ct code fields.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      inta_en <= 1'b0;
      intb_en <= 1'b0;
      prio    <= 1'b0;
      vec_a   <= VEC_A_DEFAULT;
      vec_b   <= VEC_B_DEFAULT;
    end else begin
      if (i_ct_code[3]) begin
        inta_en <= i_ct_code[0];
        intb_en <= i_ct_code[1];
        prio    <= i_ct_code[2];
      end
      case (i_ct_code[5:4])
        2'd1: vec_a <= i_data_bus;
        2'd2: vec_b <= i_data_bus;
        2'd3: begin
          vec_a <= VEC_A_DEFAULT;
          vec_b <= VEC_B_DEFAULT;
        end
        default: ;
      endcase
    end
  end

  // Pending flags: a new set in the same edge as the select wins over the clear.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      prev_a      <= 1'b0;
      prev_b      <= 1'b0;
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      soft_pend   <= 1'b0;
      soft_num    <= 5'd0;
      o_soft_drop <= 1'b0;
    end else begin
      prev_a      <= i_int_a;
      prev_b      <= i_int_b;
      pend_a      <= kill_a ? 1'b0 : ((pend_a & ~take_a) | (i_int_a & ~prev_a & inta_en));
      pend_b      <= kill_b ? 1'b0 : ((pend_b & ~take_b) | (i_int_b & ~prev_b & intb_en));
      soft_pend   <= (soft_pend & ~take_soft) | soft_accept;
      o_soft_drop <= i_ct_code[6] & soft_pend;
      if (soft_accept) soft_num <= i_ct_code[11:7];
    end
  end

  // Service sequencer; outputs are registered alongside the next state.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      vec_lat      <= 16'd0;
      o_interrupt  <= 1'b0;
      o_pc_load    <= 1'b0;
      o_int_vector <= 16'd0;
      o_int_busy   <= 1'b0;
      o_int_source <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take_soft || take_a || take_b) begin
            state        <= ASSERT;
            vec_lat      <= sel_vec;
            o_interrupt  <= 1'b1;
            o_int_busy   <= 1'b1;
            o_int_source <= sel_src;
          end
        end
        ASSERT: begin
          state        <= VECTOR;
          o_interrupt  <= 1'b0;
          o_pc_load    <= 1'b1;
          o_int_vector <= vec_lat;
        end
        VECTOR: begin
          state        <= SERVICE;
          o_pc_load    <= 1'b0;
          o_int_vector <= 16'd0;
        end
        SERVICE: begin
          if (i_iret) begin
            state        <= IDLE;
            o_int_busy   <= 1'b0;
            o_int_source <= 2'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: a table of per-cycle vectors followed by
// hand-written sequences for reset-in-flight and vector-capture corner cases.
module tb_int_controller;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [11:0] i_ct_code;
  logic [15:0] i_data_bus;
  logic        i_int_a, i_int_b, i_iret;
  logic        o_interrupt, o_pc_load, o_int_busy, o_soft_drop;
  logic [15:0] o_int_vector;
  logic [1:0]  o_int_source, dbg_state;

  int checks = 0;
  int errors = 0;

  int_controller dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_ct_code    (i_ct_code),
    .i_data_bus   (i_data_bus),
    .i_int_a      (i_int_a),
    .i_int_b      (i_int_b),
    .i_iret       (i_iret),
    .o_interrupt  (o_interrupt),
    .o_pc_load    (o_pc_load),
    .o_int_vector (o_int_vector),
    .o_int_busy   (o_int_busy),
    .o_int_source (o_int_source),
    .o_soft_drop  (o_soft_drop),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // {interrupt, pc_load, vector, busy, source, drop}
  logic [21:0] act;
  assign act = {o_interrupt, o_pc_load, o_int_vector, o_int_busy, o_int_source, o_soft_drop};

  function automatic logic [21:0] ex(logic intr, logic pcl, logic [15:0] vec,
                                     logic busy, logic [1:0] src, logic drop);
    return {intr, pcl, vec, busy, src, drop};
  endfunction

  typedef struct {
    logic [11:0] ct;
    logic [15:0] bus;
    logic        a, b, iret;
    logic [21:0] exp;
  } row_t;

  row_t tbl[$];

  function automatic void add(logic [11:0] ct, logic [15:0] bus, logic a, logic b,
                              logic iret, logic [21:0] exp);
    row_t r;
    r.ct = ct; r.bus = bus; r.a = a; r.b = b; r.iret = iret; r.exp = exp;
    tbl.push_back(r);
  endfunction

  // Driver: present inputs, let one edge sample them, settle past the edge.
  task automatic apply(input logic rst_v, input logic [11:0] ct, input logic [15:0] bus,
                       input logic a, input logic b, input logic iret);
    n_rst      = rst_v;
    i_ct_code  = ct;
    i_data_bus = bus;
    i_int_a    = a;
    i_int_b    = b;
    i_iret     = iret;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (int,pcl,vec,busy,src,drop)", name, act, exp);
    end
  endtask

  localparam logic [21:0] Z = 22'd0;

  initial begin
    // Test 1: basic A service
    add(12'h00B, 16'h0, 0, 0, 0, Z);
    add(12'h000, 16'h0, 1, 0, 0, Z);
    add(12'h000, 16'h0, 0, 0, 0, ex(1, 0, 16'h0000, 1, 2'd1, 0));
    add(12'h000, 16'h0, 0, 0, 0, ex(0, 1, 16'h0010, 1, 2'd1, 0));
    add(12'h000, 16'h0, 0, 0, 0, ex(0, 0, 16'h0000, 1, 2'd1, 0));
    add(12'h000, 16'h0, 0, 0, 1, Z);
    // Test 2: vec_b write, prio=1, simultaneous A/B
    add(12'h02F, 16'h4000, 0, 0, 0, Z);
    add(12'h000, 16'h0, 1, 1, 0, Z);
    add(12'h000, 16'h0, 0, 0, 0, ex(1, 0, 16'h0000, 1, 2'd2, 0));
    add(12'h000, 16'h0, 0, 0, 0, ex(0, 1, 16'h4000, 1, 2'd2, 0));
    add(12'h000, 16'h0, 0, 0, 0, ex(0, 0, 16'h0000, 1, 2'd2, 0));
    add(12'h000, 16'h0, 0, 0, 1, Z);
    add(12'h000, 16'h0, 0, 0, 0, ex(1, 0, 16'h0000, 1, 2'd1, 0));
    add(12'h000, 16'h0, 0, 0, 0, ex(0, 1, 16'h0010, 1, 2'd1, 0));
    add(12'h000, 16'h0, 0, 0, 0, ex(0, 0, 16'h0000, 1, 2'd1, 0));
    add(12'h000, 16'h0, 0, 0, 1, Z);
    // Test 3: soft num 20, second soft while pending is dropped
    add(12'hA40, 16'h0, 0, 0, 0, Z);
    add(12'hA40, 16'h0, 0, 0, 0, ex(1, 0, 16'h0000, 1, 2'd3, 1));
    add(12'h000, 16'h0, 0, 0, 0, ex(0, 1, 16'h0150, 1, 2'd3, 0));
    add(12'h000, 16'h0, 0, 0, 0, ex(0, 0, 16'h0000, 1, 2'd3, 0));
    add(12'h000, 16'h0, 0, 0, 1, Z);
    add(12'h000, 16'h0, 0, 0, 0, Z);
    // Test 4: A disabled edges dropped, then held-high line serviced once
    add(12'h00E, 16'h0, 0, 0, 0, Z);
    add(12'h000, 16'h0, 1, 0, 0, Z);
    add(12'h000, 16'h0, 0, 0, 0, Z);
    add(12'h000, 16'h0, 1, 0, 0, Z);
    add(12'h000, 16'h0, 0, 0, 0, Z);
    add(12'h00B, 16'h0, 0, 0, 0, Z);
    add(12'h000, 16'h0, 1, 0, 0, Z);
    add(12'h000, 16'h0, 1, 0, 0, ex(1, 0, 16'h0000, 1, 2'd1, 0));
    add(12'h000, 16'h0, 1, 0, 0, ex(0, 1, 16'h0010, 1, 2'd1, 0));
    for (int k = 0; k < 7; k++)
      add(12'h000, 16'h0, 1, 0, 0, ex(0, 0, 16'h0000, 1, 2'd1, 0));
    add(12'h000, 16'h0, 0, 0, 1, Z);
    add(12'h000, 16'h0, 0, 0, 0, Z);

    // Reset block
    apply(0, 12'h0, 16'h0, 0, 0, 0);
    apply(0, 12'h0, 16'h0, 0, 0, 0);
    check("reset_state", Z);

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      apply(1, tbl[i].ct, tbl[i].bus, tbl[i].a, tbl[i].b, tbl[i].iret);
      check($sformatf("row%0d", i), tbl[i].exp);
    end

    // Test 5: reset during VECTOR, then defaults restored; stray iret in IDLE
    apply(1, 12'h01B, 16'h1234, 0, 0, 0); check("t5_cfg", Z);
    apply(1, 12'h000, 16'h0, 1, 0, 0);    check("t5_edge", Z);
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t5_assert", ex(1, 0, 16'h0000, 1, 2'd1, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t5_vector", ex(0, 1, 16'h1234, 1, 2'd1, 0));
    apply(0, 12'h000, 16'h0, 0, 0, 0);    check("t5_rst_mid", Z);
    apply(1, 12'h000, 16'h0, 0, 0, 1);    check("t5_stray_iret", Z);
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t5_idle", Z);
    apply(1, 12'h00B, 16'h0, 0, 0, 0);    check("t5_cfg2", Z);
    apply(1, 12'h000, 16'h0, 1, 0, 0);    check("t5_edge2", Z);
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t5_assert2", ex(1, 0, 16'h0000, 1, 2'd1, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t5_default_vec", ex(0, 1, 16'h0010, 1, 2'd1, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t5_service", ex(0, 0, 16'h0000, 1, 2'd1, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 1);    check("t5_iret", Z);

    // Test 6: soft beats A in the same cycle; vec write during ASSERT not in flight
    apply(1, 12'hA40, 16'h0, 1, 0, 0);    check("t6_both", Z);
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t6_soft_first", ex(1, 0, 16'h0000, 1, 2'd3, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t6_soft_vec", ex(0, 1, 16'h0150, 1, 2'd3, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t6_soft_svc", ex(0, 0, 16'h0000, 1, 2'd3, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 1);    check("t6_iret1", Z);
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t6_a_assert", ex(1, 0, 16'h0000, 1, 2'd1, 0));
    apply(1, 12'h010, 16'h5555, 0, 0, 0); check("t6_inflight_vec", ex(0, 1, 16'h0010, 1, 2'd1, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t6_a_svc", ex(0, 0, 16'h0000, 1, 2'd1, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 1);    check("t6_iret2", Z);
    apply(1, 12'h000, 16'h0, 1, 0, 0);    check("t6_edge", Z);
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t6_assert3", ex(1, 0, 16'h0000, 1, 2'd1, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 0);    check("t6_new_vec", ex(0, 1, 16'h5555, 1, 2'd1, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 1);    check("t6_svc3", ex(0, 0, 16'h0000, 1, 2'd1, 0));
    apply(1, 12'h000, 16'h0, 0, 0, 1);    check("t6_iret3", Z);

    // Report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
